// File: rtl/clkmon_pkg.sv
// Shared definitions for the clock monitor: FSM state encoding and default widths.
package clkmon_pkg;

    // Counter width shared with the clock divider that usually feeds this monitor.
    localparam int CNT_W_DEF       = 25;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_e;

endpackage

// File: rtl/clkmon_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a history flop
// used to derive single-cycle rise/fall strobes in the clk_i domain.
module clkmon_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the asynchronous input through the synchronizer chain and keep one cycle of history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous stage's old value, which is what makes this a chain rather than a wire.
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o =  s_o & ~hist_q;
    assign fall_o = ~s_o &  hist_q;

endmodule

// File: rtl/clkmon.sv
// Pulse-width / period meter for a slow asynchronous square wave. Reports high time,
// low time and period in clk_i cycles, a duty-symmetry flag, and a sticky stall flag.
module clkmon
    import clkmon_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter int               SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT     = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] high_o,
    output logic [CNT_W-1:0] low_o,
    output logic [CNT_W:0]   period_o,
    output logic             valid_o,
    output logic             sym_o,
    output logic             timeout_o
);

    state_e            state;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  lcnt;
    logic [CNT_W-1:0]  hcnt_inc;
    logic [CNT_W-1:0]  lcnt_inc;
    logic [CNT_W:0]    period_next;
    logic signed [CNT_W:0] diff;
    logic              sym_next;
    logic              rise;
    logic              fall;
    // The synchronized level is exposed by the synchronizer but the FSM only needs the edges.
    logic              s_unused;

    clkmon_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (sig_i),
        .s_o   (s_unused),
        .rise_o(rise),
        .fall_o(fall)
    );

    // Saturating increments, period sum and symmetry test for the period being closed.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch can be inferred.
        hcnt_inc    = (&hcnt) ? hcnt : hcnt + CNT_W'(1);
        lcnt_inc    = (&lcnt) ? lcnt : lcnt + CNT_W'(1);
        period_next = {1'b0, hcnt} + {1'b0, lcnt};
        diff        = $signed({1'b0, hcnt}) - $signed({1'b0, lcnt});
        sym_next    = (diff == '0) || (diff == (CNT_W+1)'(1)) || (diff == '1);
    end

    // Measurement FSM: arm on a rise, count high then low, publish on the closing rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            hcnt      <= '0;
            lcnt      <= '0;
            high_o    <= '0;
            low_o     <= '0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            sym_o     <= 1'b0;
            timeout_o <= 1'b0;
        end else if (!en_i) begin
            // Results stay readable while disabled; only live state is cleared.
            state     <= ST_IDLE;
            hcnt      <= '0;
            lcnt      <= '0;
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_ARM;
                end
                ST_ARM: begin
                    // Whatever phase was in progress at arming is never reported.
                    if (rise) begin
                        hcnt  <= CNT_W'(1);
                        lcnt  <= '0;
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // A stall check takes priority over an edge arriving the same cycle.
                    if (hcnt == TIMEOUT) begin
                        timeout_o <= 1'b1;
                        hcnt      <= '0;
                        lcnt      <= '0;
                        state     <= ST_ARM;
                    end else if (fall) begin
                        lcnt  <= CNT_W'(1);
                        state <= ST_LOW;
                    end else begin
                        hcnt <= hcnt_inc;
                    end
                end
                ST_LOW: begin
                    if (lcnt == TIMEOUT) begin
                        timeout_o <= 1'b1;
                        hcnt      <= '0;
                        lcnt      <= '0;
                        state     <= ST_ARM;
                    end else if (rise) begin
                        high_o    <= hcnt;
                        low_o     <= lcnt;
                        period_o  <= period_next;
                        sym_o     <= sym_next;
                        valid_o   <= 1'b1;
                        timeout_o <= 1'b0;
                        hcnt      <= CNT_W'(1);
                        lcnt      <= '0;
                        state     <= ST_HIGH;
                    end else begin
                        lcnt <= lcnt_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkmon.sv
// Self-checking bench for clkmon: a timestamp-based reference model is compared with
// the DUT every cycle, with directed scenarios pinning literal results.
module tb_clkmon;

    localparam int CNT_W = 25;
    localparam int SS    = 2;
    localparam int TO    = 20;

    logic             clk_i  = 1'b0;
    logic             rst_ni = 1'b0;
    logic             en_i   = 1'b0;
    logic             sig_i  = 1'b0;
    logic [CNT_W-1:0] high_o;
    logic [CNT_W-1:0] low_o;
    logic [CNT_W:0]   period_o;
    logic             valid_o;
    logic             sym_o;
    logic             timeout_o;

    clkmon #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SS),
        .TIMEOUT    (25'd20)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en_i),
        .sig_i    (sig_i),
        .high_o   (high_o),
        .low_o    (low_o),
        .period_o (period_o),
        .valid_o  (valid_o),
        .sym_o    (sym_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timestamps of synchronized edges) ----------------
    logic [15:0] hist   = '0;
    bit          m_idle = 1'b1;
    longint      cyc    = 0;
    longint      rise_t = -1;
    longint      fall_t = -1;
    longint      e_high = 0, e_low = 0, e_per = 0;
    bit          e_sym = 0, e_valid = 0, e_to = 0;

    task automatic model_step();
        bit     s, sd, r, f;
        longint start;
        cyc++;
        if (!rst_ni) begin
            hist = '0; m_idle = 1'b1; rise_t = -1; fall_t = -1;
            e_high = 0; e_low = 0; e_per = 0; e_sym = 0; e_valid = 0; e_to = 0;
            return;
        end
        // Level seen by the FSM is sig_i sampled SS edges ago; history one edge older.
        s = hist[SS-1];
        sd = hist[SS];
        r = s && !sd;
        f = !s && sd;
        hist = {hist[14:0], sig_i};
        e_valid = 0;
        if (!en_i) begin
            m_idle = 1'b1; rise_t = -1; fall_t = -1; e_to = 0;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            start = (fall_t >= 0) ? fall_t : rise_t;
            if (start >= 0 && cyc - start == TO) begin
                e_to = 1; rise_t = -1; fall_t = -1;
            end else if (r) begin
                if (fall_t >= 0) begin
                    e_high  = fall_t - rise_t;
                    e_low   = cyc - fall_t;
                    e_per   = e_high + e_low;
                    e_sym   = ((e_high > e_low) ? e_high - e_low : e_low - e_high) <= 1;
                    e_valid = 1;
                    e_to    = 0;
                end
                rise_t = cyc;
                fall_t = -1;
            end else if (f && rise_t >= 0) begin
                fall_t = cyc;
            end
        end
    endtask

    // Compare process: advance the model on each rising edge, compare just after it.
    initial begin
        forever begin
            @(posedge clk_i);
            model_step();
            #1;
            check("cyc_valid",   valid_o,   e_valid);
            check("cyc_timeout", timeout_o, e_to);
            check("cyc_high",    high_o,    e_high);
            check("cyc_low",     low_o,     e_low);
            check("cyc_period",  period_o,  e_per);
            check("cyc_sym",     sym_o,     e_sym);
        end
    end

    // ---------------- square-wave generator ----------------
    int hi_len = 5, lo_len = 5;
    bit gen_on = 0, gen_rand = 0, hold_level = 0;

    initial begin
        forever begin
            if (gen_on) begin
                if (gen_rand) begin
                    hi_len = $urandom_range(1, 24);
                    lo_len = $urandom_range(1, 24);
                end
                sig_i = 1'b1;
                repeat (hi_len) @(negedge clk_i);
                sig_i = 1'b0;
                repeat (lo_len) @(negedge clk_i);
            end else begin
                sig_i = hold_level;
                @(negedge clk_i);
            end
        end
    end

    task automatic wait_valid(input int budget, output int n, output bit ok);
        ok = 0; n = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #2;
            if (valid_o === 1'b1) begin
                ok = 1; n = i + 1;
                return;
            end
        end
    endtask

    task automatic wait_timeout(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            #2;
            if (timeout_o === 1'b1) begin
                ok = 1;
                return;
            end
        end
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        int n, nv;
        bit ok;

        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // Symmetric 5/5 wave.
        hi_len = 5; lo_len = 5; gen_on = 1; en_i = 1'b1;
        wait_valid(100, n, ok);
        check("t1_seen", ok, 1);
        check("t1_high", high_o, 5);
        check("t1_low", low_o, 5);
        check("t1_period", period_o, 10);
        check("t1_sym", sym_o, 1);
        wait_valid(30, n, ok);
        check("t1_spacing", n, 10);

        // Asymmetric 7/3 wave.
        hi_len = 7; lo_len = 3;
        repeat (3) wait_valid(40, n, ok);
        check("t2_seen", ok, 1);
        check("t2_high", high_o, 7);
        check("t2_low", low_o, 3);
        check("t2_period", period_o, 10);
        check("t2_sym", sym_o, 0);

        // Stall high, then resume.
        hold_level = 1; gen_on = 0;
        wait_timeout(80, ok);
        check("t3_timeout_seen", ok, 1);
        check("t3_high_held", high_o, 7);
        hi_len = 5; lo_len = 5; gen_on = 1;
        wait_valid(80, n, ok);
        check("t3_resume_seen", ok, 1);
        check("t3_timeout_cleared", timeout_o, 0);
        check("t3_high", high_o, 5);

        // Disable in the middle of the low phase.
        wait_valid(30, n, ok);
        repeat (7) @(posedge clk_i);
        @(negedge clk_i);
        en_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("t4_valid_low", valid_o, 0);
        check("t4_timeout_low", timeout_o, 0);
        check("t4_high_held", high_o, 5);
        check("t4_low_held", low_o, 5);
        @(negedge clk_i);
        en_i = 1'b1;
        wait_valid(60, n, ok);
        check("t4_reenable_seen", ok, 1);
        check("t4_high", high_o, 5);
        check("t4_low", low_o, 5);

        // Asynchronous reset in the middle of the high phase.
        wait_valid(30, n, ok);
        #3;
        rst_ni = 1'b0;
        #1;
        check("t5_high_rst", high_o, 0);
        check("t5_low_rst", low_o, 0);
        check("t5_period_rst", period_o, 0);
        check("t5_valid_rst", valid_o, 0);
        check("t5_sym_rst", sym_o, 0);
        check("t5_timeout_rst", timeout_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        wait_valid(60, n, ok);
        check("t5_after_seen", ok, 1);
        check("t5_full_period_first", n >= 10, 1);

        // High phase exactly TIMEOUT long: stall wins over the falling edge.
        hi_len = TO; lo_len = 5;
        repeat (40) @(negedge clk_i);
        en_i = 1'b0;
        @(negedge clk_i);
        en_i = 1'b1;
        wait_timeout(120, ok);
        check("t6_timeout_seen", ok, 1);
        nv = 0;
        repeat (100) begin
            @(posedge clk_i);
            #2;
            if (valid_o === 1'b1) nv++;
        end
        check("t6_no_valid", nv, 0);
        check("t6_timeout_sticky", timeout_o, 1);

        // Random phase lengths with occasional enable drops.
        gen_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if ($urandom_range(0, 299) == 0) begin
                en_i = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk_i);
                en_i = 1'b1;
            end
        end

        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clkmon.md
Name: clkmon

Overview:
- Measures a slow, asynchronous square-wave input (e.g. a divided clock produced elsewhere in the lab designs) against the system clock.
- Reports high time, low time and period in clk_i cycles, plus a duty-symmetry flag.
- Raises a timeout when the input stops toggling.
- Used as a self-check on divided-clock outputs and as a generic pulse-width meter on the board.

Parameters:
- CNT_W, 25: width of the high and low counters; period output is CNT_W+1 bits.
- SYNC_STAGES, 2: synchronizer depth for sig_i; minimum 2.
- TIMEOUT, 25'h1FFFFFF: count value at which a stalled phase is declared dead; must be ≤ 2^CNT_W-1.

Ports:
- clk_i, input, 1: system clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- en_i, input, 1: measurement enable; low forces IDLE.
- sig_i, input, 1: asynchronous signal under measurement.
- high_o, output, CNT_W: last measured high time in cycles.
- low_o, output, CNT_W: last measured low time in cycles.
- period_o, output, CNT_W+1: high_o+low_o of the last full period.
- valid_o, output, 1: one-cycle pulse when high_o/low_o/period_o/sym_o update.
- sym_o, output, 1: 1 when |high-low| ≤ 1 for the last period.
- timeout_o, output, 1: sticky stall indicator.

Behaviour:
- One clock, clk_i. Asynchronous active-low reset rst_ni.
- Reset values: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- Synchronizer: SYNC_STAGES flops on sig_i, then one history flop.
  - rise = s & ~s_d; fall = ~s & s_d, where s is the synchronized value.
  - Edge detect lags sig_i by SYNC_STAGES..SYNC_STAGES+1 cycles.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: when en_i=1, go to ARM.
  - ARM: discard partial phases; on rise, hcnt<=1 and go to HIGH.
  - HIGH: hcnt saturating-increments each cycle. On fall, lcnt<=1 and go to LOW.
  - LOW: lcnt saturating-increments each cycle. On rise:
    - high_o<=hcnt, low_o<=lcnt, period_o<=hcnt+lcnt (zero-extended, no overflow).
    - sym_o<=(|hcnt-lcnt|≤1), valid_o<=1 for exactly one cycle.
    - timeout_o<=0, hcnt<=1, stay measuring (go to HIGH).
- Counting rule: the edge-detect cycle counts as cycle 1 of the new phase. A clean square wave with N high and M low synchronized cycles reports exactly high_o=N, low_o=M.
- First valid_o: only after one complete high+low pair following ARM. The first partial phase is never reported.
- Timeout:
  - In HIGH or LOW, if the active counter reaches TIMEOUT, set timeout_o=1, clear both counters and go to ARM.
  - timeout_o stays set until the next valid_o or until en_i=0.
- en_i=0 (any state):
  - Next cycle: state IDLE, counters 0, valid_o=0, timeout_o=0.
  - high_o, low_o, period_o and sym_o hold their last values.
- Edge in the same cycle as reaching TIMEOUT: timeout wins and the edge is discarded. This cannot occur for TIMEOUT greater than the real phase length.
- Synchronizer keeps running in IDLE, so re-enable never sees a stale edge older than SYNC_STAGES+1 cycles.
- Reset mid-measurement: immediate return to reset values. No valid_o is emitted for the interrupted period.
- Glitches shorter than one clk_i period may be missed. Debounce is not in scope.
- Arithmetic: counters are unsigned and saturate at all ones. sym_o compares CNT_W+1-bit signed difference.

Decomposition:
- Shared package/include clk_defs:
  - FSM state encodings (IDLE=2'd0, ARM=2'd1, HIGH=2'd2, LOW=2'd3).
  - Default CNT_W, used jointly by the divider and this monitor.
- One sub-module, sync_edge: parameterized SYNC_STAGES synchronizer plus history flop. Outputs s, rise, fall. Async active-low reset.
- FSM, counters and output registers live in clkmon.

Test Plan:
1. Divider with CLKIN=50, CLKOUT=5 (reload 4) drives sig_i, en_i=1. Expected: first valid_o after one full period following ARM; high_o=5, low_o=5, period_o=10, sym_o=1; valid_o repeats every 10 cycles.
2. Asymmetric stimulus, 7 cycles high / 3 low. Expected: high_o=7, low_o=3, period_o=10, sym_o=0.
3. TIMEOUT=20, sig_i held high after ARM and a rise. Expected: timeout_o=1 on the cycle after hcnt hits 20, state ARM. Resuming a 5/5 toggle then gives a valid_o with timeout_o=0 at that pulse.
4. en_i dropped mid-LOW. Expected: the next cycle shows valid_o=0, timeout_o=0, and high_o/low_o unchanged. Re-enabling yields a correct measurement after one full period.
5. rst_ni asserted asynchronously mid-HIGH (not clock-aligned). Expected: all outputs 0 immediately. After release, no valid_o until one full period has been seen.
6. Simultaneous edge and TIMEOUT (phase length exactly TIMEOUT). Expected: timeout_o=1, no valid_o that cycle, FSM in ARM.
